// File: rtl/norm_seq.sv
// norm_seq: sequencer for the column normalization array.
// Accepts a frame of N = col*pr psum words, writes each one into the array,
// waits div_wait cycles for the divides to settle, then reads N results back
// and returns them downstream through a one-entry output register.
//
// Handshake rule (upstream and downstream alike): a word moves in the cycle
// where valid and ready are both high at the rising clock edge; valid, once
// raised, is held with stable data until that happens, and ready may depend
// combinationally on the current state but never on the other side's valid.
module norm_seq #(
    parameter int pr       = 8,
    parameter int bw       = 4,
    parameter int psum_bw  = 2*bw+4,
    parameter int col      = 8,
    parameter int div_wait = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw-1:0]     in_data,
    output logic                   norm_wr,
    output logic [psum_bw-1:0]     norm_wdata,
    output logic                   norm_rd,
    input  logic [2*psum_bw-1:0]   norm_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*psum_bw-1:0]   out_data,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state_o
);

    localparam int N  = col*pr;
    localparam int CW = $clog2(N+1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(N-1);
    localparam logic [3:0]    WAIT_LAST = 4'(div_wait-1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [2*psum_bw-1:0]   out_data_q, out_data_d;
    logic                   done_q, done_d;

    // Next-state logic, counters and array strobes for each phase of a frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        norm_wr    = 1'b0;
        norm_wdata = '0;
        norm_rd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle itself ignores start, so frames are spaced
                // by at least one idle cycle after the done pulse.
                if (start && !done_q) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                in_ready   = 1'b1;
                norm_wr    = in_valid;
                norm_wdata = in_data;
                if (in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Only read when the output register is free or emptying now.
                norm_rd = !out_valid_q || out_ready;
                if (norm_rd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: load on each array read, otherwise drain on out_ready.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (norm_rd) begin
            out_valid_d = 1'b1;
            out_data_d  = norm_rdata;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath flops, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
